// File: rtl/reconfig_const_div_if.sv
// Handshake bundle for reconfig_const_div: input (y_in, s_in) and output (x_out, out_err) channels.
// chk_err exists only when RECONFIG_DIV_CHECK_EN is defined.
interface reconfig_const_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y_in;
  logic             s_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x_out;
  logic             out_err;
`ifdef RECONFIG_DIV_CHECK_EN
  logic             chk_err;

  modport master (
    output in_valid, y_in, s_in, out_ready,
    input  in_ready, out_valid, x_out, out_err, chk_err
  );
  modport slave (
    input  in_valid, y_in, s_in, out_ready,
    output in_ready, out_valid, x_out, out_err, chk_err
  );
`else
  modport master (
    output in_valid, y_in, s_in, out_ready,
    input  in_ready, out_valid, x_out, out_err
  );
  modport slave (
    input  in_valid, y_in, s_in, out_ready,
    output in_ready, out_valid, x_out, out_err
  );
`endif
endinterface

// File: rtl/reconfig_const_div.sv
// Bit-serial exact (Hensel) divider inverting y = x*6161 (s=0) or y = x*20746 (s=1), mod 2^32.
// Optional RECONFIG_DIV_CHECK_EN adds chk_err: a forward re-multiply self-check of each result.
module reconfig_const_div #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned C_ODD0 = 6161,
  parameter int unsigned C_ODD1 = 10373
) (
  input logic                 clk,
  input logic                 rst,
  reconfig_const_div_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] r, c, q;
  logic [CNT_W-1:0] cnt;
  logic             s, err;
  logic             in_ready_q, out_valid_q, out_err_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] r_nxt, q_nxt, x_nxt;

  // c is odd, so subtracting c<<i clears bit i of r and leaves lower bits untouched.
  always_comb begin
    r_nxt = r;
    q_nxt = q;
    if (r[cnt]) begin
      q_nxt[cnt] = 1'b1;
      r_nxt      = r - (c << cnt);
    end
    x_nxt = err ? '0 : (s ? {1'b0, q_nxt[WIDTH-2:0]} : q_nxt);
  end

`ifdef RECONFIG_DIV_CHECK_EN
  logic [WIDTH-1:0] y_q;
  logic             chk_q;

  // 6161x = 3x<<11 + 17x ; 20746x = (5x*2049 + x<<7) << 1 -- three adders each.
  function automatic logic [WIDTH-1:0] mult(input logic [WIDTH-1:0] x, input logic sel);
    logic [WIDTH-1:0] a, b;
    if (sel) begin
      a = x + (x << 2);
      b = a + (a << 11);
      return (b + (x << 7)) << 1;
    end else begin
      a = x + (x << 1);
      b = x + (x << 4);
      return (a << 11) + b;
    end
  endfunction

  assign bus.chk_err = chk_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_q;
  assign bus.out_err   = out_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      x_q         <= '0;
      r           <= '0;
      q           <= '0;
      c           <= '0;
      cnt         <= '0;
      s           <= 1'b0;
      err         <= 1'b0;
`ifdef RECONFIG_DIV_CHECK_EN
      y_q         <= '0;
      chk_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= RUN;
            in_ready_q <= 1'b0;
            s          <= bus.s_in;
            r          <= bus.s_in ? {1'b0, bus.y_in[WIDTH-1:1]} : bus.y_in;
            c          <= bus.s_in ? WIDTH'(C_ODD1) : WIDTH'(C_ODD0);
            q          <= '0;
            cnt        <= '0;
            err        <= bus.s_in & bus.y_in[0];
`ifdef RECONFIG_DIV_CHECK_EN
            y_q        <= bus.y_in;
`endif
          end
        end
        RUN: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            x_q         <= x_nxt;
            out_err_q   <= err;
            out_valid_q <= 1'b1;
`ifdef RECONFIG_DIV_CHECK_EN
            chk_q       <= (mult(x_nxt, s) != y_q) && !err;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reconfig_const_div.sv
// Self-checking bench for reconfig_const_div: directed vector table, handshake/reset sequences,
// and randomized round trips against a modular-inverse reference model.
module tb_reconfig_const_div;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reconfig_const_div_if #(.WIDTH(32)) bus();

  reconfig_const_div #(
    .WIDTH (32),
    .C_ODD0(6161),
    .C_ODD1(10373)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] y;
    logic        s;
    logic [31:0] x;
    logic        e;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inverse of an odd c modulo 2^32 by Newton iteration (correct bits double each step).
  function automatic logic [31:0] inv32(input logic [31:0] c);
    logic [31:0] v = c;
    for (int i = 0; i < 5; i++) v = v * (32'd2 - c * v);
    return v;
  endfunction

  function automatic logic [31:0] mul_model(input logic [31:0] x, input logic s);
    return s ? x * 32'd20746 : x * 32'd6161;
  endfunction

  function automatic logic [31:0] div_model(input logic [31:0] y, input logic s);
    if (s && y[0]) return 32'd0;
    if (s) return ((y >> 1) * inv32(32'd10373)) & 32'h7FFF_FFFF;
    return y * inv32(32'd6161);
  endfunction

  task automatic run_txn(input logic [31:0] y, input logic s, input int hold,
                         output logic [31:0] x, output logic e, output logic ck, output int lat);
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.y_in      = y;
    bus.s_in      = s;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.y_in     = $urandom;
    bus.s_in     = 1'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    x = bus.x_out;
    e = bus.out_err;
`ifdef RECONFIG_DIV_CHECK_EN
    ck = bus.chk_err;
`else
    ck = 1'b0;
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("hold_x_stable", bus.x_out, x);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_x_kept", bus.x_out, x);
  endtask

  task automatic do_vec(input string name, input logic [31:0] y, input logic s,
                        input logic [31:0] ex, input logic ee, input int hold);
    logic [31:0] x;
    logic        e, ck;
    int          lat;
    run_txn(y, s, hold, x, e, ck, lat);
    check({name, "_x"}, x, ex);
    check({name, "_err"}, 32'(e), 32'(ee));
    check({name, "_latency"}, 32'(lat), 32'd33);
`ifdef RECONFIG_DIV_CHECK_EN
    check({name, "_chk_err"}, 32'(ck), 32'd0);
`endif
    if (!ee) check({name, "_roundtrip"}, mul_model(x, s), y);
  endtask

  initial begin
    logic [31:0] xr, yr;
    logic        sr;

    tbl[0] = '{y: 32'd6161,        s: 1'b0, x: 32'd1,          e: 1'b0};
    tbl[1] = '{y: 32'hFFFF_E7EF,   s: 1'b0, x: 32'hFFFF_FFFF,  e: 1'b0};
    tbl[2] = '{y: 32'd0,           s: 1'b0, x: 32'd0,          e: 1'b0};
    tbl[3] = '{y: 32'd20746,       s: 1'b1, x: 32'd1,          e: 1'b0};
    tbl[4] = '{y: 32'd62238,       s: 1'b1, x: 32'd3,          e: 1'b0};
    tbl[5] = '{y: 32'd5,           s: 1'b1, x: 32'd0,          e: 1'b1};
    tbl[6] = '{y: 32'd12322,       s: 1'b0, x: 32'd2,          e: 1'b0};
    tbl[7] = '{y: 32'd0,           s: 1'b1, x: 32'd0,          e: 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.y_in      = '0;
    bus.s_in      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_x_out", bus.x_out, 32'd0);
    check("reset_out_err", 32'(bus.out_err), 32'd0);
`ifdef RECONFIG_DIV_CHECK_EN
    check("reset_chk_err", 32'(bus.chk_err), 32'd0);
`endif

    for (int i = 0; i < 8; i++) do_vec($sformatf("vec%0d", i), tbl[i].y, tbl[i].s, tbl[i].x, tbl[i].e, 0);

    // Output held under backpressure, with in_valid asserted while busy.
    do_vec("backpressure", 32'd62238, 1'b1, 32'd3, 1'b0, 10);

    // Reset in the middle of RUN, with cnt at 15.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.y_in     = 32'd12322;
    bus.s_in     = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_rst_x_out", bus.x_out, 32'd0);
    repeat (40) begin
      @(negedge clk);
      check("midrun_no_stale_valid", 32'(bus.out_valid), 32'd0);
    end
    do_vec("after_rst", 32'd6161, 1'b0, 32'd1, 1'b0, 0);

    // Reset while a result waits in DONE.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.y_in     = 32'd20746;
    bus.s_in     = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (35) @(negedge clk);
    check("done_before_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("done_rst_valid", 32'(bus.out_valid), 32'd0);
    check("done_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Random round trips through the multiplier model.
    for (int n = 0; n < 300; n++) begin
      xr = $urandom;
      sr = 1'($urandom);
      yr = mul_model(xr, sr);
      do_vec("rand_mul", yr, sr, sr ? (xr & 32'h7FFF_FFFF) : xr, 1'b0, 0);
    end

    // Random raw y, including unsolvable odd y with s=1.
    for (int n = 0; n < 100; n++) begin
      yr = $urandom;
      sr = 1'($urandom);
      do_vec("rand_raw", yr, sr, div_model(yr, sr), sr & yr[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
